// File: rtl/sr_lock_arbiter.sv
`default_nettype none
// ==========================================================================
// sr_lock_arbiter : round-robin owner of a shared SR_ff lock flag; sequences s/r, confirms q
// Revision 1.0
// ==========================================================================
module sr_lock_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] rel,
  input  logic            q,
  output logic            s,
  output logic            r,
  output logic [NREQ-1:0] gnt,
  output logic            busy,
  output logic            err
);

  localparam int              c_pw      = $clog2(NREQ);
  localparam int              c_cw      = $clog2(TIMEOUT + 1);
  localparam logic [c_cw-1:0] c_timeout = c_cw'(TIMEOUT);
  localparam logic [c_pw-1:0] c_last    = c_pw'(NREQ - 1);
  localparam logic [NREQ-1:0] c_one     = NREQ'(1);

  localparam logic [2:0] ST_INIT_CLR = 3'd0;
  localparam logic [2:0] ST_IDLE     = 3'd1;
  localparam logic [2:0] ST_SET      = 3'd2;
  localparam logic [2:0] ST_WAIT_SET = 3'd3;
  localparam logic [2:0] ST_OWNED    = 3'd4;
  localparam logic [2:0] ST_CLR      = 3'd5;
  localparam logic [2:0] ST_WAIT_CLR = 3'd6;
  localparam logic [2:0] ST_ERROR    = 3'd7;

  logic [2:0]      r_state;
  logic [2:0]      w_next;
  logic [c_pw-1:0] r_ptr;
  logic [c_pw-1:0] r_win;
  logic [c_cw-1:0] r_cnt;
  logic            r_init;
  logic [c_pw-1:0] w_pick;
  logic [c_pw-1:0] w_cand;
  logic            w_found;
  logic [c_cw-1:0] w_cnt_inc;
  logic            w_s;
  logic            w_r;
  logic [NREQ-1:0] w_gnt;
  logic            w_busy;
  logic            w_err;

  // Round-robin search starting at ptr, wrapping past NREQ-1.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_ptr;
    w_cand  = r_ptr;
    for (int i = 0; i < NREQ; i++) begin
      w_cand = c_pw'((int'(r_ptr) + i) % NREQ);
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  assign w_cnt_inc = (r_cnt == c_timeout) ? r_cnt : r_cnt + c_cw'(1);

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_INIT_CLR;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_INIT_CLR: w_next = ST_WAIT_CLR;
      ST_IDLE: begin
        if (q)            w_next = ST_ERROR;
        else if (w_found) w_next = ST_SET;
      end
      ST_SET: w_next = ST_WAIT_SET;
      ST_WAIT_SET: begin
        if (q)                            w_next = ST_OWNED;
        else if (w_cnt_inc == c_timeout)  w_next = ST_ERROR;
      end
      ST_OWNED: begin
        if (!q)              w_next = ST_ERROR;
        else if (rel[r_win]) w_next = ST_CLR;
      end
      ST_CLR: w_next = ST_WAIT_CLR;
      ST_WAIT_CLR: begin
        if (!q)                           w_next = ST_IDLE;
        else if (w_cnt_inc == c_timeout)  w_next = ST_ERROR;
      end
      ST_ERROR: w_next = ST_ERROR;
      default:  w_next = ST_ERROR;
    endcase
  end

  // Output values for the state being entered; the INIT_CLR clear pulse lands in WAIT_CLR.
  always_comb begin
    w_s    = (w_next == ST_SET);
    w_r    = (w_next == ST_CLR) || (r_state == ST_INIT_CLR);
    w_gnt  = (w_next == ST_OWNED) ? (c_one << r_win) : '0;
    w_busy = (w_next != ST_IDLE);
    w_err  = (w_next == ST_ERROR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s      <= 1'b0;
      r      <= 1'b0;
      gnt    <= '0;
      busy   <= 1'b1;
      err    <= 1'b0;
      r_ptr  <= '0;
      r_win  <= '0;
      r_cnt  <= '0;
      r_init <= 1'b1;
    end else begin
      s    <= w_s;
      r    <= w_r;
      gnt  <= w_gnt;
      busy <= w_busy;
      err  <= w_err;
      if (r_state == ST_IDLE && w_next == ST_SET)
        r_win <= w_pick;
      if (r_state == ST_SET || r_state == ST_CLR)
        r_cnt <= '0;
      else if (r_state == ST_WAIT_SET || r_state == ST_WAIT_CLR)
        r_cnt <= w_cnt_inc;
      // The power-up clear has no owner, so the pointer only advances after a real release.
      if (r_state == ST_WAIT_CLR && w_next == ST_IDLE) begin
        r_init <= 1'b0;
        if (!r_init)
          r_ptr <= (r_win == c_last) ? '0 : r_win + c_pw'(1);
      end
    end
  end

  a_s_r_exclusive: assert property (@(posedge clk) !(s && r));
  a_gnt_onehot0:   assert property (@(posedge clk) $onehot0(gnt));
  a_gnt_owned:     assert property (@(posedge clk) (gnt != '0) |-> (r_state == ST_OWNED));

endmodule
`default_nettype wire
